// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// One instance per port (core load/store, I/O loader).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory
// between the core load/store port and the I/O port.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     io,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic              cerr_q, cerr_d;
  logic              ierr_q, ierr_d;

  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic              res_wr;
  logic              res_sel;
  logic [DATA_W-1:0] res_val;
  logic              res_err;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    crd_d    = crd_q;
    ird_d    = ird_q;
    cerr_d   = cerr_q;
    ierr_d   = ierr_q;
    res_wr   = 1'b0;
    res_sel  = grant_q;
    res_val  = '0;
    res_err  = 1'b0;
    // io wins when alone, or on a tie when the core went last
    win      = io.req & (~cpu.req | ~last_q);
    sel_addr = win ? io.addr : cpu.addr;

    unique case (state_q)
      IDLE: begin
        if (cpu.req | io.req) begin
          grant_d = win;
          last_d  = win;
          we_d    = win ? io.we : cpu.we;
          addr_d  = sel_addr[ADDR_W-1:2];
          wdata_d = win ? io.wdata : cpu.wdata;
          if (sel_addr[1:0] != 2'b00) begin
            state_d = DONE;
            res_wr  = 1'b1;
            res_sel = win;
            res_err = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
          res_wr  = 1'b1;
          res_val = we_q ? '0 : mem_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (res_wr) begin
      if (res_sel) begin
        ird_d  = res_val;
        ierr_d = res_err;
      end else begin
        crd_d  = res_val;
        cerr_d = res_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      ird_q   <= '0;
      cerr_q  <= 1'b0;
      ierr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      ird_q   <= ird_d;
      cerr_q  <= cerr_d;
      ierr_q  <= ierr_d;
    end
  end

  // strobes drop in the reset cycle itself, not one cycle later
  assign mem_en    = (state_q == ACCESS) & ~rst;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu.ack   = (state_q == DONE) & ~rst & ~grant_q;
  assign io.ack    = (state_q == DONE) & ~rst & grant_q;
  assign cpu.rdata = crd_q;
  assign io.rdata  = ird_q;
  assign cpu.err   = cerr_q & cpu.ack;
  assign io.err    = ierr_q & io.ack;

  assign cpu_stall = cpu.req & ~cpu.ack;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Random bench for dmem_arbiter at MEM_LAT=1 and MEM_LAT=3,
// checked cycle by cycle against a transaction-timeline model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  localparam int NCYC = 3000;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101_0011;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam string PFX = (g == 0) ? "L1 " : "L3 ";

    logic        rst;
    logic        cpu_stall, mem_en, mem_we, busy, grant_id;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] bmem [16];
    logic [31:0] pipe [LAT];
    bit          done = 1'b0;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) io_if ();

    dmem_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(LAT)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu      (cpu_if),
      .io       (io_if),
      .cpu_stall(cpu_stall),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .grant_id (grant_id)
    );

    // memory: read data appears LAT cycles after mem_en, junk otherwise
    assign mem_rdata = pipe[LAT-1];
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) bmem[i] <= init_word(i);
      end else if (mem_en && mem_we) begin
        bmem[mem_addr[3:0]] <= mem_wdata;
      end
      pipe[0] <= (mem_en && !mem_we) ? bmem[mem_addr[3:0]] : $urandom;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    bit          d_req  [2];
    bit          d_we   [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wd   [2];
    int          quiet  [2];

    assign cpu_if.req   = d_req[0];
    assign cpu_if.we    = d_we[0];
    assign cpu_if.addr  = d_addr[0];
    assign cpu_if.wdata = d_wd[0];
    assign io_if.req    = d_req[1];
    assign io_if.we     = d_we[1];
    assign io_if.addr   = d_addr[1];
    assign io_if.wdata  = d_wd[1];

    logic [31:0] ref_mem [16];
    bit          m_act, m_own, m_we, m_mis, m_last, m_gid;
    int          m_t, m_len;
    logic [31:0] m_addr, m_wd;
    logic [31:0] m_rd [2];
    bit          m_er [2];
    bit          e_ack [2];
    bit          e_en, r;
    int          preq;
    logic [31:0] a;

    task m_reset();
      m_act  = 1'b0;
      m_own  = 1'b0;
      m_we   = 1'b0;
      m_mis  = 1'b0;
      m_last = 1'b1;
      m_gid  = 1'b0;
      m_t    = 0;
      m_len  = 0;
      m_addr = '0;
      m_wd   = '0;
      for (int p = 0; p < 2; p++) begin
        m_rd[p] = '0;
        m_er[p] = 1'b0;
      end
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    initial begin
      rst = 1'b1;
      m_reset();
      for (int p = 0; p < 2; p++) begin
        d_req[p]  = 1'b0;
        d_we[p]   = 1'b0;
        d_addr[p] = '0;
        d_wd[p]   = '0;
        quiet[p]  = 0;
      end
      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #1;
        r    = (c < 3) || (c > 600 && $urandom_range(0, 149) == 0);
        rst  = r;
        preq = (c < 400) ? 100 : 30;
        #1;
        e_en = m_act && !m_mis && m_t == 1 && !r;
        for (int p = 0; p < 2; p++)
          e_ack[p] = m_act && m_t == m_len && m_own == 1'(p) && !r;
        if (m_act && m_t == m_len) begin
          m_rd[m_own] = (m_mis || m_we) ? 32'h0 : ref_mem[m_addr[5:2]];
          m_er[m_own] = m_mis;
        end
        if (e_en && m_we) ref_mem[m_addr[5:2]] = m_wd;

        chk({PFX, "busy"}, 64'(busy), 64'(m_act));
        chk({PFX, "grant_id"}, 64'(grant_id), 64'(m_gid));
        chk({PFX, "mem_en"}, 64'(mem_en), 64'(e_en));
        chk({PFX, "mem_we"}, 64'(mem_we), 64'(e_en && m_we));
        if (e_en) begin
          chk({PFX, "mem_addr"}, 64'(mem_addr), 64'(m_addr[31:2]));
          chk({PFX, "mem_wdata"}, 64'(mem_wdata), 64'(m_wd));
        end
        chk({PFX, "cpu_ack"}, 64'(cpu_if.ack), 64'(e_ack[0]));
        chk({PFX, "io_ack"}, 64'(io_if.ack), 64'(e_ack[1]));
        chk({PFX, "cpu_rdata"}, 64'(cpu_if.rdata), 64'(m_rd[0]));
        chk({PFX, "io_rdata"}, 64'(io_if.rdata), 64'(m_rd[1]));
        chk({PFX, "cpu_err"}, 64'(cpu_if.err), 64'(m_er[0] && e_ack[0]));
        chk({PFX, "io_err"}, 64'(io_if.err), 64'(m_er[1] && e_ack[1]));

        for (int p = 0; p < 2; p++) begin
          if (quiet[p] > 0) quiet[p]--;
          if (d_req[p] && e_ack[p]) begin
            d_req[p] = 1'b0;
          end else if (d_req[p] && m_act && m_own == 1'(p) &&
                       m_t < m_len && c > 600 &&
                       $urandom_range(0, 9) == 0) begin
            d_req[p] = 1'b0;
            quiet[p] = LAT + 4;
          end
          if (!d_req[p] && quiet[p] == 0 &&
              $urandom_range(0, 99) < preq) begin
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d_req[p]  = 1'b1;
            d_we[p]   = ($urandom_range(0, 2) == 0);
            d_addr[p] = a;
            d_wd[p]   = $urandom;
          end
        end
        #1;
        chk({PFX, "cpu_stall"}, 64'(cpu_stall), 64'(d_req[0] && !e_ack[0]));

        if (r) begin
          m_reset();
        end else if (m_act) begin
          if (m_t == m_len) m_act = 1'b0;
          else m_t++;
        end else if (d_req[0] || d_req[1]) begin
          m_own  = d_req[1] && (!d_req[0] || !m_last);
          m_last = m_own;
          m_gid  = m_own;
          m_we   = d_we[m_own];
          m_addr = d_addr[m_own];
          m_wd   = d_wd[m_own];
          m_mis  = (m_addr[1:0] != 2'b00);
          m_len  = m_mis ? 1 : LAT + 2;
          m_t    = 1;
          m_act  = 1'b1;
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    wait (u[0].done && u[1].done);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
